mem_req_ctrl: RTL and testbench

//  Upstream request controller for the byte-wide memory_dut. Accepts host read/write requests

---
 rtl/mem_req_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_req_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - queued, in-order request controller in front of a byte-wide memory
module mem_req_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 8,
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_wr,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_wr_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  localparam int RQ_PW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int RS_PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int RQ_CW = $clog2(REQ_DEPTH + 1);
  localparam int RS_CW = $clog2(RSP_DEPTH + 1);
  localparam int RS_SW = RS_CW + 1;

  logic              rq_wr    [REQ_DEPTH];
  logic [ADDR_W-1:0] rq_addr  [REQ_DEPTH];
  logic [DATA_W-1:0] rq_wdata [REQ_DEPTH];
  logic [RQ_PW-1:0]  rq_wptr, rq_rptr;
  logic [RQ_CW-1:0]  rq_count, rq_count_next;
  logic              rq_push, rq_pop;
  logic              head_err;

  logic              s1_v, s1_wr, s1_err;
  logic              s2_v, s2_wr, s2_err;

  logic              rs_wr    [RSP_DEPTH];
  logic              rs_err   [RSP_DEPTH];
  logic [DATA_W-1:0] rs_rdata [RSP_DEPTH];
  logic [RS_PW-1:0]  rs_wptr, rs_rptr;
  logic [RS_CW-1:0]  rs_count, rs_count_next;
  logic              rs_push, rs_pop;
  logic [DATA_W-1:0] cap_rdata;
  logic [RS_SW-1:0]  credit_used;

  // Handshakes, credit-gated issue and the FIFO occupancy updates
  always_comb begin
    rq_push       = req_valid && req_ready;
    credit_used   = RS_SW'(rs_count) + RS_SW'(s1_v) + RS_SW'(s2_v);
    rq_pop        = (rq_count != '0) && (credit_used < RS_SW'(RSP_DEPTH));
    rq_count_next = rq_count + RQ_CW'(rq_push) - RQ_CW'(rq_pop);
    head_err      = rq_addr[rq_rptr] >= ADDR_W'(MEM_DEPTH);
    rs_push       = s2_v;
    rs_pop        = rsp_valid && rsp_ready;
    rs_count_next = rs_count + RS_CW'(rs_push) - RS_CW'(rs_pop);
    cap_rdata     = (s2_wr || s2_err) ? '0 : mem_data_out;
  end

  // Request FIFO storage, written on accept
  always_ff @(posedge clock) begin
    if (rq_push) begin
      rq_wr[rq_wptr]    <= req_wr;
      rq_addr[rq_wptr]  <= req_addr;
      rq_wdata[rq_wptr] <= req_wdata;
    end
  end

  // Request FIFO pointers, occupancy and registered ready
  always_ff @(posedge clock) begin
    if (reset) begin
      rq_wptr   <= '0;
      rq_rptr   <= '0;
      rq_count  <= '0;
      req_ready <= 1'b0;
    end else begin
      if (rq_push) rq_wptr <= rq_wptr + RQ_PW'(1);
      if (rq_pop)  rq_rptr <= rq_rptr + RQ_PW'(1);
      rq_count  <= rq_count_next;
      req_ready <= rq_count_next < RQ_CW'(REQ_DEPTH);
    end
  end

  // Stage s1: drive the memory pins; bad addresses become a read of location 0
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_v        <= 1'b0;
      s1_wr       <= 1'b0;
      s1_err      <= 1'b0;
      mem_wr_rd   <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
    end else begin
      s1_v <= rq_pop;
      if (rq_pop) begin
        s1_wr       <= rq_wr[rq_rptr];
        s1_err      <= head_err;
        mem_wr_rd   <= rq_wr[rq_rptr] && !head_err;
        mem_addr    <= head_err ? '0 : rq_addr[rq_rptr];
        mem_data_in <= rq_wdata[rq_rptr];
      end else begin
        mem_wr_rd <= 1'b0;
      end
    end
  end

  // Stage s2: tracks the request while the memory executes it
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_v   <= 1'b0;
      s2_wr  <= 1'b0;
      s2_err <= 1'b0;
    end else begin
      s2_v   <= s1_v;
      s2_wr  <= s1_wr;
      s2_err <= s1_err;
    end
  end

  // Response FIFO storage, written when s2 captures memory output
  always_ff @(posedge clock) begin
    if (rs_push) begin
      rs_wr[rs_wptr]    <= s2_wr;
      rs_err[rs_wptr]   <= s2_err;
      rs_rdata[rs_wptr] <= cap_rdata;
    end
  end

  // Response FIFO pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      rs_wptr  <= '0;
      rs_rptr  <= '0;
      rs_count <= '0;
    end else begin
      if (rs_push) rs_wptr <= rs_wptr + RS_PW'(1);
      if (rs_pop)  rs_rptr <= rs_rptr + RS_PW'(1);
      rs_count <= rs_count_next;
    end
  end

  // Response head is masked to zero while empty so stale storage never shows
  always_comb begin
    rsp_valid = rs_count != '0;
    rsp_wr    = rsp_valid && rs_wr[rs_rptr];
    rsp_err   = rsp_valid && rs_err[rs_rptr];
    rsp_rdata = rsp_valid ? rs_rdata[rs_rptr] : '0;
    busy      = (rq_count != '0) || s1_v || s2_v || rsp_valid;
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - randomized self-checking bench for mem_req_ctrl
module tb_mem_req_ctrl;

  typedef logic [9:0] rsp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_wr;
  logic        rsp_err;
  logic [7:0]  rsp_rdata;
  logic        mem_wr_rd;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_in;
  logic [7:0]  mem_data_out = '0;
  logic        busy;

  int   checks = 0;
  int   failures = 0;
  rsp_t exp_q[$];
  rsp_t got_q[$];
  logic [7:0] ref_mem [8];
  logic [7:0] tb_mem  [8];
  int   good_wr = 0;
  int   mem_wr_seen = 0;
  int   addr_viol = 0;
  int   stable_viol = 0;
  int   send_timeouts = 0;
  bit   hold_pending = 1'b0;
  rsp_t held = '0;
  bit   rand_rdy = 1'b0;

  always #5 clock = ~clock;

  mem_req_ctrl dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .busy(busy)
  );

  // Byte-wide memory with registered read port
  always @(posedge clock) begin
    if (mem_wr_rd) tb_mem[mem_addr[2:0]] <= mem_data_in;
    else           mem_data_out <= tb_mem[mem_addr[2:0]];
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      tb_mem[i]  = 8'h00;
      ref_mem[i] = 8'h00;
    end
  end

  // Reference model: each accepted request's response is decided at accept time
  always @(negedge clock) begin
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        if (req_addr >= 32'd8) begin
          exp_q.push_back({req_wr, 1'b1, 8'h00});
        end else if (req_wr) begin
          ref_mem[req_addr[2:0]] = req_wdata;
          good_wr++;
          exp_q.push_back({1'b1, 1'b0, 8'h00});
        end else begin
          exp_q.push_back({1'b0, 1'b0, ref_mem[req_addr[2:0]]});
        end
      end
      if (rsp_valid && rsp_ready) got_q.push_back({rsp_wr, rsp_err, rsp_rdata});
      if (mem_wr_rd) mem_wr_seen++;
      if (mem_addr >= 32'd8) addr_viol++;
      if (hold_pending && (!rsp_valid || {rsp_wr, rsp_err, rsp_rdata} !== held)) stable_viol++;
      hold_pending = rsp_valid && !rsp_ready;
      held = {rsp_wr, rsp_err, rsp_rdata};
    end
  end

  // Random response backpressure when enabled
  always @(posedge clock) begin
    #1;
    if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic wr, input logic [31:0] addr, input logic [7:0] d, output int n);
    bit acc = 1'b0;
    n = 0;
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = d;
    while (!acc && n < 200) begin
      @(negedge clock);
      acc = req_ready;
      @(posedge clock);
      #1;
      n++;
    end
    if (!acc) send_timeouts++;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(output bit to);
    int n = 0;
    while ((busy || exp_q.size() != got_q.size()) && n < 400) begin
      @(posedge clock);
      #1;
      n++;
    end
    to = (n >= 400);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({req_ready, rsp_valid, rsp_wr, rsp_err, rsp_rdata, mem_wr_rd, mem_addr, mem_data_in, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ready=%b rv=%b wr=%b err=%b rd=%h mwr=%b maddr=%h mdin=%h busy=%b exp all 0",
               req_ready, rsp_valid, rsp_wr, rsp_err, rsp_rdata, mem_wr_rd, mem_addr, mem_data_in, busy);
    end
    @(posedge clock); #1; reset = 1'b0;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL ready_lag got=%b exp=0", req_ready); end
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL ready_rise got=%b exp=1", req_ready); end
    @(posedge clock); #1;
  endtask

  task automatic test_write_read();
    int n, lat;
    bit to;
    rsp_t e, g;
    rsp_ready = 1'b1;
    send(1'b1, 32'd3, 8'hA5, n);
    lat = 0;
    while (lat < 20) begin
      @(negedge clock);
      if (rsp_valid) break;
      @(posedge clock);
      lat++;
    end
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL t1_latency got=%0d exp=3", lat); end
    @(posedge clock); #1;
    send(1'b0, 32'd3, 8'h00, n);
    wait_drain(to);
    checks++;
    if (to) begin failures++; $display("FAIL t1_drain got=timeout exp=drained"); end
    checks++;
    if (got_q.size() != 2) begin failures++; $display("FAIL t1_count got=%0d exp=2", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL t1_rsp got=%h exp=%h", g, e); end
    end
    checks++;
    if (ref_mem[3] !== 8'hA5) begin failures++; $display("FAIL t1_model got=%h exp=a5", ref_mem[3]); end
  endtask

  task automatic test_raw();
    int n;
    bit to;
    rsp_t e, g;
    rsp_ready = 1'b1;
    send(1'b1, 32'd5, 8'h3C, n);
    send(1'b0, 32'd5, 8'h00, n);
    wait_drain(to);
    checks++;
    if (to) begin failures++; $display("FAIL t2_drain got=timeout exp=drained"); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL t2_rsp got=%h exp=%h", g, e); end
    end
    checks++;
    if (tb_mem[5] !== 8'h3C) begin failures++; $display("FAIL t2_memcell got=%h exp=3c", tb_mem[5]); end
  endtask

  task automatic test_addr_err();
    int n;
    bit to;
    rsp_t e, g;
    rsp_ready = 1'b1;
    send(1'b0, 32'd8, 8'h00, n);
    send(1'b1, 32'd8, 8'hFF, n);
    send(1'b0, 32'h8000_0003, 8'h00, n);
    send(1'b1, 32'hFFFF_FFF9, 8'h77, n);
    send(1'b0, 32'd7, 8'h00, n);
    wait_drain(to);
    checks++;
    if (to) begin failures++; $display("FAIL t3_drain got=timeout exp=drained"); end
    checks++;
    if (got_q.size() != 5) begin failures++; $display("FAIL t3_count got=%0d exp=5", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL t3_rsp got=%h exp=%h", g, e); end
    end
    checks++;
    if (mem_wr_seen !== good_wr) begin failures++; $display("FAIL t3_mem_writes got=%0d exp=%0d", mem_wr_seen, good_wr); end
    checks++;
    if (addr_viol !== 0) begin failures++; $display("FAIL t3_mem_addr_range got=%0d exp=0", addr_viol); end
  endtask

  task automatic test_backpressure();
    int n, seen;
    bit to;
    rsp_t e, g;
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(1'b0, 32'(i), 8'h00, n);
    repeat (4) begin @(posedge clock); #1; end
    @(negedge clock);
    checks++;
    if ({req_ready, rsp_valid, busy, mem_wr_rd} !== 4'b0110) begin
      failures++;
      $display("FAIL t4_full got ready=%b rv=%b busy=%b mwr=%b exp 0 1 1 0", req_ready, rsp_valid, busy, mem_wr_rd);
    end
    checks++;
    if (mem_addr !== 32'd3) begin failures++; $display("FAIL t4_no_issue got=%h exp=3", mem_addr); end
    checks++;
    if (exp_q.size() != 8) begin failures++; $display("FAIL t4_accepted got=%0d exp=8", exp_q.size()); end
    @(posedge clock); #1;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'd0;
    seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (req_ready) seen++;
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL t4_ready_low got=%0d exp=0", seen); end
    rsp_ready = 1'b1;
    wait_drain(to);
    checks++;
    if (to) begin failures++; $display("FAIL t4_drain got=timeout exp=drained"); end
    checks++;
    if (got_q.size() != 8) begin failures++; $display("FAIL t4_count got=%0d exp=8", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL t4_rsp got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_mid_reset();
    int n;
    bit to;
    rsp_t e, g;
    rsp_ready = 1'b1;
    send(1'b1, 32'd6, 8'h5A, n);
    wait_drain(to);
    void'(exp_q.pop_front());
    void'(got_q.pop_front());
    send(1'b0, 32'd1, 8'h00, n);
    send(1'b0, 32'd2, 8'h00, n);
    send(1'b0, 32'd6, 8'h00, n);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({req_ready, rsp_valid, busy, mem_wr_rd} !== 4'b0000) begin
      failures++;
      $display("FAIL t5_after_reset got ready=%b rv=%b busy=%b mwr=%b exp 0 0 0 0", req_ready, rsp_valid, busy, mem_wr_rd);
    end
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL t5_ready_back got=%b exp=1", req_ready); end
    exp_q.delete();
    got_q.delete();
    repeat (6) begin @(posedge clock); #1; end
    checks++;
    if (got_q.size() != 0) begin failures++; $display("FAIL t5_dropped got=%0d exp=0", got_q.size()); end
    send(1'b0, 32'd6, 8'h00, n);
    wait_drain(to);
    checks++;
    if (got_q.size() != 1) begin failures++; $display("FAIL t5_count got=%0d exp=1", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== {2'b00, 8'h5A}) begin failures++; $display("FAIL t5_readback got=%h exp=05a", g); end
      checks++;
      if (g !== e) begin failures++; $display("FAIL t5_rsp got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_back_to_back();
    int n, total;
    bit to;
    rsp_t e, g;
    rsp_ready = 1'b1;
    total = 0;
    for (int i = 0; i < 16; i++) begin
      send(1'(i % 2 == 0), 32'(i / 2), 8'($urandom_range(0, 255)), n);
      total += n;
    end
    checks++;
    if (total !== 16) begin failures++; $display("FAIL t6_throughput got=%0d cycles exp=16", total); end
    wait_drain(to);
    checks++;
    if (to) begin failures++; $display("FAIL t6_drain got=timeout exp=drained"); end
    checks++;
    if (got_q.size() != 16) begin failures++; $display("FAIL t6_count got=%0d exp=16", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL t6_rsp got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_random();
    int n, r;
    bit to;
    logic [31:0] a;
    rsp_t e, g;
    rand_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      r = int'($urandom_range(0, 9));
      a = (r == 9) ? ($urandom | 32'h0000_0100) : 32'(r);
      send(1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)), n);
      if ($urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
    end
    rand_rdy = 1'b0;
    @(posedge clock); #2;
    rsp_ready = 1'b1;
    wait_drain(to);
    checks++;
    if (to) begin failures++; $display("FAIL rnd_drain got=timeout exp=drained"); end
    checks++;
    if (got_q.size() != 100) begin failures++; $display("FAIL rnd_count got=%0d exp=100", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL rnd_rsp got=%h exp=%h", g, e); end
    end
    checks++;
    if (stable_viol !== 0) begin failures++; $display("FAIL rsp_hold_stable got=%0d exp=0", stable_viol); end
    checks++;
    if (mem_wr_seen !== good_wr) begin failures++; $display("FAIL rnd_mem_writes got=%0d exp=%0d", mem_wr_seen, good_wr); end
    checks++;
    if (addr_viol !== 0) begin failures++; $display("FAIL rnd_mem_addr_range got=%0d exp=0", addr_viol); end
    checks++;
    if (send_timeouts !== 0) begin failures++; $display("FAIL accept_timeouts got=%0d exp=0", send_timeouts); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_raw();
    test_addr_err();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
